// File: rtl/digest_hex_tx.sv
// digest_hex_tx
//
// Prints a 256-bit digest as 64 ASCII hex characters followed by a line feed (8'h0A),
// one character per handshake with a byte-wide UART transmitter. The most significant
// nibble (hash_in[255:252]) goes out first. A configurable idle gap separates characters.
//
// Parameters
//   CHAR_DELAY  idle cycles inserted between consecutive characters (0 = no gap)
//   UPPERCASE   0: hex letters a-f, 1: hex letters A-F
//
// Ports
//   clk         single clock, all logic on the rising edge
//   reset       synchronous, active-high reset
//   hash_in     digest to print, sampled when hash_valid is seen in IDLE
//   hash_valid  single-cycle capture strobe, ignored outside IDLE
//   tx_done     from the UART: high once the current character has been shifted out
//   tx_en       request to the UART to send tx_data
//   tx_data     ASCII character presented to the UART
//   busy        high from capture until the block is back in IDLE
//   done        one-cycle pulse after the terminating LF has been sent
//   char_idx    index of the current character, 0..64 (64 is the LF)

module digest_hex_tx #(
    parameter int unsigned CHAR_DELAY = 1000,
    parameter int unsigned UPPERCASE  = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [255:0] hash_in,
    input  logic         hash_valid,
    input  logic         tx_done,
    output logic         tx_en,
    output logic [7:0]   tx_data,
    output logic         busy,
    output logic         done,
    output logic [6:0]   char_idx
);

    localparam logic [6:0]  LastIdx = 7'd64;
    localparam logic [7:0]  LineFeed = 8'h0A;
    // Last GAP count value; only meaningful when CHAR_DELAY is non-zero.
    localparam logic [31:0] GapLast = 32'(CHAR_DELAY - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWaitClr,
        StSend,
        StGap,
        StFin
    } state_e;

    state_e         state_q, state_d;
    logic [255:0]   digest_q, digest_d;
    logic [6:0]     idx_q, idx_d;
    logic [7:0]     data_q, data_d;
    logic [31:0]    gap_q, gap_d;
    logic           tx_en_q;
    logic           busy_q;
    logic           done_q;

    // Digest viewed as 64 nibbles; nibble 63 holds bits [255:252] and is printed first.
    logic [63:0][3:0] nibbles;
    logic [3:0]       cur_nibble;

    assign nibbles    = digest_q;
    assign cur_nibble = nibbles[6'd63 - idx_q[5:0]];

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        logic [7:0] letter_base;
        letter_base = (UPPERCASE != 0) ? 8'h41 : 8'h61;
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return letter_base + {4'h0, n} - 8'd10;
    endfunction

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        digest_d = digest_q;
        idx_d    = idx_q;
        data_d   = data_q;
        gap_d    = gap_q;

        unique case (state_q)
            StIdle: begin
                if (hash_valid) begin
                    digest_d = hash_in;
                    idx_d    = 7'd0;
                    state_d  = StLoad;
                end
            end

            StLoad: begin
                data_d  = (idx_q == LastIdx) ? LineFeed : hex_char(cur_nibble);
                state_d = StWaitClr;
            end

            // A tx_done still high from the previous character must not be taken as
            // completion of this one, so wait for it to fall first.
            StWaitClr: begin
                if (!tx_done) begin
                    state_d = StSend;
                end
            end

            StSend: begin
                if (tx_done) begin
                    if (idx_q == LastIdx) begin
                        state_d = StFin;
                    end else begin
                        idx_d   = idx_q + 7'd1;
                        gap_d   = 32'd0;
                        state_d = (CHAR_DELAY == 0) ? StLoad : StGap;
                    end
                end
            end

            // gap_q counts cycles already spent here; leaving at GapLast gives exactly
            // CHAR_DELAY cycles. The counter saturates rather than wrapping.
            StGap: begin
                if (gap_q == GapLast) begin
                    gap_d   = 32'd0;
                    state_d = StLoad;
                end else if (gap_q != 32'hFFFF_FFFF) begin
                    gap_d = gap_q + 32'd1;
                end
            end

            StFin: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and registered outputs. The Moore outputs are registered from state_d so
    // that they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            digest_q <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            gap_q    <= '0;
            tx_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            digest_q <= digest_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            gap_q    <= gap_d;
            tx_en_q  <= (state_d == StSend);
            busy_q   <= (state_d != StIdle);
            done_q   <= (state_d == StFin);
        end
    end

    assign tx_en    = tx_en_q;
    assign tx_data  = data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign char_idx = idx_q;

endmodule

// File: tb/tb_digest_hex_tx.sv
// Bench for digest_hex_tx: two instances (lowercase with a 4-cycle gap, uppercase with
// no gap) driven by a cycle-level UART model; the expected text is computed from the
// digest with plain arithmetic.

module tb_digest_hex_tx;

    logic         clk;
    logic         reset;
    logic [255:0] hin  [2];
    logic         hv   [2];
    logic         txd  [2];
    logic         ten  [2];
    logic [7:0]   tdat [2];
    logic         bsy  [2];
    logic         dn   [2];
    logic [6:0]   cidx [2];

    int n_vec;
    int n_err;

    digest_hex_tx #(
        .CHAR_DELAY (4),
        .UPPERCASE  (0)
    ) dut_lo (
        .clk        (clk),
        .reset      (reset),
        .hash_in    (hin[0]),
        .hash_valid (hv[0]),
        .tx_done    (txd[0]),
        .tx_en      (ten[0]),
        .tx_data    (tdat[0]),
        .busy       (bsy[0]),
        .done       (dn[0]),
        .char_idx   (cidx[0])
    );

    digest_hex_tx #(
        .CHAR_DELAY (0),
        .UPPERCASE  (1)
    ) dut_up (
        .clk        (clk),
        .reset      (reset),
        .hash_in    (hin[1]),
        .hash_valid (hv[1]),
        .tx_done    (txd[1]),
        .tx_en      (ten[1]),
        .tx_data    (tdat[1]),
        .busy       (bsy[1]),
        .done       (dn[1]),
        .char_idx   (cidx[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Character i of the printed line for digest d.
    function automatic logic [7:0] exp_char(input logic [255:0] d, input int i, input bit upper);
        int n;
        if (i == 64) return 8'h0A;
        n = int'((d >> (252 - 4 * i)) & 256'hF);
        if (n < 10) return 8'(48 + n);
        return 8'((upper ? 65 : 97) + n - 10);
    endfunction

    function automatic logic [255:0] rand_digest();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    // Sends one digest and monitors the whole transfer. Must be called at a negedge.
    //   lat     cycles of tx_en before the UART model raises tx_done
    //   stale   extra cycles tx_done is held high after each acknowledge
    //   intr_at char index at which a second hash_valid is pulsed (-1: never)
    //   rst_at  reset is asserted after this many handshakes complete (-1: never)
    task automatic run_digest(input int sel, input logic [255:0] dig, input int lat,
                              input int stale, input int intr_at, input int rst_at);
        logic [7:0]   got[$];
        logic [7:0]   held;
        logic [255:0] other;
        int hs, dones, en_cnt, stale_left, post;
        bit prev_en, prev_done, drv_done, ack_prev, rst_next, rst_pend, aborted;

        hs = 0; dones = 0; en_cnt = 0; stale_left = 0; post = -1;
        prev_en = 0; prev_done = 0; drv_done = 0; ack_prev = 0;
        rst_next = 0; rst_pend = 0; aborted = 0;
        held = 8'h00;
        other = ~dig ^ rand_digest();

        hv[sel]  = 1'b1;
        hin[sel] = dig;
        for (int cyc = 1; cyc <= 30000; cyc++) begin
            @(negedge clk);
            hv[sel]  = 1'b0;
            hin[sel] = other;

            if (rst_pend) begin
                chk("reset_tx_en", 32'(ten[sel]), 0);
                chk("reset_busy", 32'(bsy[sel]), 0);
                chk("reset_done", 32'(dn[sel]), 0);
                chk("reset_char_idx", 32'(cidx[sel]), 0);
                chk("reset_tx_data", 32'(tdat[sel]), 0);
                reset      = 1'b0;
                rst_pend   = 0;
                aborted    = 1;
                stale_left = 0;
                drv_done   = 0;
                txd[sel]   = 1'b0;
                prev_en    = ten[sel];
                post       = 0;
                continue;
            end

            if (ack_prev) chk("tx_en_drop_after_done", 32'(ten[sel]), 0);
            ack_prev = 0;

            if (ten[sel] && !prev_en) begin
                chk("tx_en_rise_with_done_low", 32'(drv_done), 0);
                if (hs == 0) chk("first_tx_en_latency", 32'(cyc), 3);
                chk("char_idx_at_send", 32'(cidx[sel]), 32'(hs));
                got.push_back(tdat[sel]);
                held   = tdat[sel];
                en_cnt = 0;
                if (hs == intr_at) begin
                    hv[sel]  = 1'b1;
                    hin[sel] = other;
                end
                hs++;
            end
            if (ten[sel]) begin
                chk("tx_data_stable", 32'(tdat[sel]), 32'(held));
                en_cnt++;
            end

            if (prev_done) begin
                chk("done_single_cycle", 32'(dn[sel]), 0);
                chk("busy_after_done", 32'(bsy[sel]), 0);
            end
            if (dn[sel]) begin
                dones++;
                chk("char_idx_at_done", 32'(cidx[sel]), 64);
                chk("busy_during_done", 32'(bsy[sel]), 1);
                // Capture strobe coincident with the done pulse must be ignored.
                hv[sel]  = 1'b1;
                hin[sel] = other;
                if (post < 0) post = 0;
            end
            prev_done = dn[sel];
            prev_en   = ten[sel];

            if (rst_next) begin
                reset    = 1'b1;
                rst_next = 0;
                rst_pend = 1;
            end

            // UART model: drives tx_done for the next rising edge.
            if (ten[sel] && en_cnt == lat) begin
                drv_done   = 1;
                stale_left = stale;
                ack_prev   = 1;
                if (hs == rst_at) rst_next = 1;
            end else if (stale_left > 0) begin
                drv_done = 1;
                stale_left--;
            end else begin
                drv_done = 0;
            end
            txd[sel] = drv_done;

            if (post >= 0) post++;
            if (post > 20) break;
        end
        txd[sel] = 1'b0;
        hv[sel]  = 1'b0;

        chk("transfer_completed", 32'(post > 20), 1);
        chk("busy_at_end", 32'(bsy[sel]), 0);
        if (aborted) begin
            chk("handshakes_before_reset", 32'(hs), 32'(rst_at));
            chk("no_done_after_reset", 32'(dones), 0);
        end else begin
            chk("handshake_count", 32'(hs), 65);
            chk("done_pulse_count", 32'(dones), 1);
        end
        for (int i = 0; i < got.size() && i < 65; i++) begin
            chk($sformatf("char[%0d]", i), 32'(got[i]), 32'(exp_char(dig, i, sel == 1)));
        end
    endtask

    initial begin
        logic [255:0] d;
        n_vec = 0;
        n_err = 0;

        // Reset together with hash_valid: reset wins.
        reset = 1'b1;
        for (int s = 0; s < 2; s++) begin
            hv[s]  = 1'b1;
            hin[s] = rand_digest();
            txd[s] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("por_tx_en", 32'(ten[s]), 0);
            chk("por_tx_data", 32'(tdat[s]), 0);
            chk("por_busy", 32'(bsy[s]), 0);
            chk("por_done", 32'(dn[s]), 0);
            chk("por_char_idx", 32'(cidx[s]), 0);
            hv[s] = 1'b0;
        end
        reset = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) chk("reset_beats_hash_valid", 32'(bsy[s]), 0);

        // Known pattern, slow UART.
        d = {4{64'h0123456789abcdef}};
        run_digest(0, d, 10, 0, -1, -1);

        // All ones in both letter cases.
        run_digest(0, {256{1'b1}}, 3, 0, -1, -1);
        run_digest(1, {256{1'b1}}, 2, 0, -1, -1);

        // Second capture strobe mid-transfer is ignored.
        run_digest(0, rand_digest(), 2, 0, 20, -1);

        // Reset after the 10th handshake, then a fresh digest.
        run_digest(0, rand_digest(), 2, 0, -1, 10);
        run_digest(0, rand_digest(), 2, 0, -1, -1);

        // tx_done held high well into WAIT_CLR after every character.
        run_digest(0, rand_digest(), 3, 10, -1, -1);

        // No gap, tx_done the cycle after tx_en, then random UART latencies.
        run_digest(1, rand_digest(), 1, 0, -1, -1);
        run_digest(1, rand_digest(), 1, 0, -1, -1);
        run_digest(1, rand_digest(), int'($urandom_range(1, 5)), 0, -1, -1);
        run_digest(0, rand_digest(), int'($urandom_range(1, 5)), 0, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
